floo_xy_route_stage: RTL and testbench
======================================

Name: floo_xy_route_stage

Overview:
- Router input-port stage sitting directly upstream of the router crossbar.
- Consumes flits with destination coordinates and computes the output port as a `floo_pkg::route_direction_e` value using XY dimension-ordered routing (`floo_pkg::XYRouting`).
- Buffers flits in a small FIFO.
- Locks the computed direction for every flit of a multi-flit packet, from the head flit through the last flit.

Parameters:
- `XWidth`, 3, width of the X coordinate.
- `YWidth`, 3, width of the Y coordinate.
- `NumX`, 4, mesh columns; legal X range is 0..NumX-1.
- `NumY`, 4, mesh rows; legal Y range is 0..NumY-1.
- `DataWidth`, 64, flit payload width.
- `FifoDepth`, 2, number of buffer entries; must be ≥1; a power of two is not required.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `my_x_i`  in  XWidth  this router's X coordinate; quasi-static.
- `my_y_i`  in  YWidth  this router's Y coordinate; quasi-static.
- `valid_i`  in  1  input flit valid.
- `ready_o`  out  1  input ready.
- `data_i`  in  DataWidth  flit payload.
- `dst_x_i`  in  XWidth  destination X; sampled on head flits only.
- `dst_y_i`  in  YWidth  destination Y; sampled on head flits only.
- `last_i`  in  1  last flit of the packet; a single-flit packet has `last_i`=1 on its head flit.
- `valid_o`  out  NumDirections(5)  one-hot per-direction valid, indexed by `route_direction_e`.
- `ready_i`  in  5  per-direction ready from the crossbar.
- `data_o`  out  DataWidth  head-of-FIFO payload.
- `last_o`  out  1  head-of-FIFO last flag.
- `dir_o`  out  3  head-of-FIFO direction, encoded as `route_direction_e`.
- `err_o`  out  1  sticky routing error; see Optional Feature.

Behaviour:
- Reset (asynchronous, `rst_i`=1):
  - FIFO is emptied and the packet FSM goes to `Head`.
  - Outputs: `valid_o`=0, `ready_o`=1 (after reset is released), `data_o`=0, `last_o`=0, `dir_o`=North (0), `err_o`=0.
- Input handshake:
  - A flit is accepted when `valid_i && ready_o`.
  - `ready_o` = !full; it does not depend on a same-cycle pop, so there is no combinational path from `ready_i` to `ready_o`.
- XY route function, evaluated on the head flit only:
  - dst_x > my_x → East.
  - dst_x < my_x → West.
  - Otherwise, dst_y > my_y → North.
  - Otherwise, dst_y < my_y → South.
  - Otherwise → Eject.
  - Comparisons are unsigned.
- Packet FSM, advanced on each accepted flit:
  - `Head`: compute direction, store it in `lock_dir_q`.
    - `last_i`=1 → stay in `Head`.
    - `last_i`=0 → go to `Body`.
  - `Body`: flit takes `lock_dir_q`; `dst_*` inputs are ignored.
    - `last_i`=1 → return to `Head`.
- FIFO:
  - Each entry holds {data, last, dir}.
  - Latency: a flit accepted in cycle N is visible on the outputs in cycle N+1; there is no fall-through.
  - `valid_o[d]` = !empty && head.dir==d; at most one bit is set.
  - Pop when `valid_o[dir_o] && ready_i[dir_o]`. Ready bits for other directions are ignored.
  - Simultaneous push and pop when not full: both happen and the occupancy is unchanged.
  - Push while full cannot happen (`ready_o`=0).
  - Read/write pointers wrap at FifoDepth-1 back to 0.
- When empty, `data_o`/`last_o`/`dir_o` hold their last value (reset value after reset). Consumers ignore them while `valid_o`=0.
- Output stability: while a `valid_o` bit is high and not popped, `data_o`/`last_o`/`dir_o` hold stable.
- Reset mid-packet: the partial packet is discarded and the FSM returns to `Head`. The next accepted flit is treated as a head flit.

Optional Feature:
- Macro: `FLOO_XY_ROUTE_ERR_EN`.
- Defined:
  - A head flit with dst_x ≥ NumX or dst_y ≥ NumY marks its packet as dropped.
  - The head and all body flits up to and including last are accepted (`ready_o` per the normal full rule) but not enqueued.
  - `err_o` is set in the cycle after the head is accepted and stays set until reset.
  - Implemented with an extra FSM state, `Drop`.
- Undefined:
  - No range check; such packets are routed purely by the XY compare.
  - `err_o` is tied to 0.

Decomposition:
- Add to `floo_pkg`:
  - `xy_route_state_e` {`Head`, `Body`, `Drop`}.
  - Function `xy_route_dir(dst_x, dst_y, my_x, my_y)` returning `route_direction_e`, reused by other routers.
- `route_direction_e` and `NumDirections` already come from `floo_pkg`.
- One sub-module, `floo_route_fifo`: a generic {payload, dir} FIFO with full/empty flags.

Test Plan:
- Routes with my=(1,1), single-flit packets, `ready_i`=5'b11111:
  - dst (3,0) → `valid_o`=East bit, `dir_o`=1.
  - dst (0,2) → West (3).
  - dst (1,3) → North (0).
  - dst (1,0) → South (2).
  - dst (1,1) → Eject (4).
  - Each appears exactly 1 cycle after acceptance.
- Locked direction: 4-flit packet with head dst (3,1), then body flits with `dst_x_i`=0 → all four flits exit East, `last_o`=1 only on flit 4. FSM is back in `Head`, and the next head with dst (0,1) exits West.
- Backpressure: `ready_i`[East]=0 while streaming East flits, with FifoDepth=2 → `ready_o`=0 after 2 accepts, `data_o` stable. Other `ready_i` bits high have no effect. Raising `ready_i`[East] drains the flits in order, one per cycle.
- Full throughput: continuous `valid_i` with ready high → one flit accepted and one emitted per cycle, no bubbles after the first cycle.
- Reset: assert `rst_i` after the head and 1 body flit of a 3-flit packet → `valid_o`=0 immediately (asynchronous). After release, the next flit with dst (2,1) is routed as a head (East).
- With `FLOO_XY_ROUTE_ERR_EN`, NumX=4: head dst (5,0), 3-flit packet → no `valid_o` pulses, `err_o`=1 from the cycle after the head onward. A following packet with dst (0,1) routes West normally.

Source files
------------

// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared FlooNoC routing types, constants and the XY route function
//
// Purpose: routing algorithm and direction enums, packet-FSM state enum for the
// XY route stage, and the reusable XY dimension-ordered route function.
// Ports: none (package).
package floo_pkg;

  typedef enum logic [1:0] {
    XYRouting     = 2'd0,
    IdTable       = 2'd1,
    SourceRouting = 2'd2
  } route_algo_e;

  typedef enum logic [2:0] {
    North = 3'd0,
    East  = 3'd1,
    South = 3'd2,
    West  = 3'd3,
    Eject = 3'd4
  } route_direction_e;

  localparam int unsigned NumDirections = 5;

  // Coordinates of any router width are zero-extended to this width before
  // being handed to xy_route_dir, so one function serves every mesh size.
  localparam int unsigned MaxCoordWidth = 8;

  typedef enum logic [1:0] {
    Head = 2'd0,
    Body = 2'd1,
    Drop = 2'd2
  } xy_route_state_e;

  // X is resolved first, then Y; equal in both dimensions means local eject.
  function automatic route_direction_e xy_route_dir(
    input logic [MaxCoordWidth-1:0] dstX,
    input logic [MaxCoordWidth-1:0] dstY,
    input logic [MaxCoordWidth-1:0] myX,
    input logic [MaxCoordWidth-1:0] myY
  );
    route_direction_e dir;
    if (dstX > myX) begin
      dir = East;
    end else if (dstX < myX) begin
      dir = West;
    end else if (dstY > myY) begin
      dir = North;
    end else if (dstY < myY) begin
      dir = South;
    end else begin
      dir = Eject;
    end
    return dir;
  endfunction

endpackage

// File: rtl/floo_route_fifo.sv
// rtl/floo_route_fifo.sv - generic {payload, dir} FIFO with full/empty flags
//
// Purpose: small circular buffer with registered (non fall-through) output.
// While empty the head outputs repeat the last popped entry (zero after reset).
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   push, pushPayload, pushDir   write side; push ignored while full
//   pop              read side; ignored while empty
//   full, empty      occupancy flags
//   headPayload, headDir         current head entry
module floo_route_fifo #(
  parameter int unsigned PayloadWidth = 65,
  parameter int unsigned Depth        = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic [PayloadWidth-1:0] pushPayload,
  input  logic [2:0]              pushDir,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic [PayloadWidth-1:0] headPayload,
  output logic [2:0]              headDir
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [PayloadWidth-1:0] payloadMem [Depth];
  logic [2:0]              dirMem     [Depth];

  logic [PtrWidth-1:0]     wrPtrQ, rdPtrQ;
  logic [CntWidth-1:0]     countQ;
  logic [PayloadWidth-1:0] holdPayloadQ;
  logic [2:0]              holdDirQ;
  logic                    doPush, doPop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (countQ == CntWidth'(Depth));
  assign empty  = (countQ == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtrQ       <= '0;
      rdPtrQ       <= '0;
      countQ       <= '0;
      holdPayloadQ <= '0;
      holdDirQ     <= '0;
    end else begin
      if (doPush) begin
        wrPtrQ <= nextPtr(wrPtrQ);
      end
      if (doPop) begin
        rdPtrQ       <= nextPtr(rdPtrQ);
        holdPayloadQ <= payloadMem[rdPtrQ];
        holdDirQ     <= dirMem[rdPtrQ];
      end
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Storage needs no reset: it is only observed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      payloadMem[wrPtrQ] <= pushPayload;
      dirMem[wrPtrQ]     <= pushDir;
    end
  end

  assign headPayload = empty ? holdPayloadQ : payloadMem[rdPtrQ];
  assign headDir     = empty ? holdDirQ     : dirMem[rdPtrQ];

endmodule

// File: rtl/floo_xy_route_stage.sv
// rtl/floo_xy_route_stage.sv - router input stage: XY route, direction lock, flit FIFO
//
// Purpose: computes the XY output direction on each head flit, locks it for the
// body flits of the packet, and buffers flits toward the crossbar.
// Optional macro FLOO_XY_ROUTE_ERR_EN: drops packets whose head destination is
// outside the mesh and raises a sticky err_o.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   my_x_i, my_y_i               this router's coordinates
//   valid_i, ready_o, data_i, dst_x_i, dst_y_i, last_i   flit input
//   valid_o[dir], ready_i[dir]   one-hot per-direction handshake
//   data_o, last_o, dir_o        head-of-FIFO flit
//   err_o                        sticky out-of-range routing error
module floo_xy_route_stage
  import floo_pkg::*;
#(
  parameter int unsigned XWidth    = 3,
  parameter int unsigned YWidth    = 3,
  parameter int unsigned NumX      = 4,
  parameter int unsigned NumY      = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [XWidth-1:0]        my_x_i,
  input  logic [YWidth-1:0]        my_y_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [DataWidth-1:0]     data_i,
  input  logic [XWidth-1:0]        dst_x_i,
  input  logic [YWidth-1:0]        dst_y_i,
  input  logic                     last_i,
  output logic [NumDirections-1:0] valid_o,
  input  logic [NumDirections-1:0] ready_i,
  output logic [DataWidth-1:0]     data_o,
  output logic                     last_o,
  output logic [2:0]               dir_o,
  output logic                     err_o
);

  if (FifoDepth < 1 || NumX < 1 || NumY < 1 ||
      XWidth > MaxCoordWidth || YWidth > MaxCoordWidth) begin : gBadConfig
    $error("floo_xy_route_stage: illegal parameter combination");
  end

  xy_route_state_e  stateQ, stateD;
  route_direction_e lockDirQ, lockDirD;
  route_direction_e routeDir, pushDir;

  logic                 accept, push, pop, full, empty;
  logic [DataWidth:0]   headPayload;
  logic [2:0]           headDir;

  assign ready_o = !full;
  assign accept  = valid_i && !full;

  assign routeDir = xy_route_dir(MaxCoordWidth'(dst_x_i), MaxCoordWidth'(dst_y_i),
                                 MaxCoordWidth'(my_x_i), MaxCoordWidth'(my_y_i));

`ifdef FLOO_XY_ROUTE_ERR_EN
  logic outOfRange;
  logic errQ;

  assign outOfRange = (32'(dst_x_i) >= NumX) || (32'(dst_y_i) >= NumY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errQ <= 1'b0;
    end else if (accept && stateQ == Head && outOfRange) begin
      errQ <= 1'b1;
    end
  end

  assign err_o = errQ;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ   <= Head;
      lockDirQ <= North;
    end else begin
      stateQ   <= stateD;
      lockDirQ <= lockDirD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    lockDirD = lockDirQ;
    pushDir  = lockDirQ;
    push     = 1'b0;
    case (stateQ)
      Head: begin
        pushDir = routeDir;
        if (accept) begin
          lockDirD = routeDir;
          push     = 1'b1;
          stateD   = last_i ? Head : Body;
`ifdef FLOO_XY_ROUTE_ERR_EN
          if (outOfRange) begin
            push   = 1'b0;
            stateD = last_i ? Head : Drop;
          end
`endif
        end
      end
      Body: begin
        if (accept) begin
          push = 1'b1;
          if (last_i) stateD = Head;
        end
      end
      Drop: begin
        // Remaining flits of a rejected packet are consumed without enqueueing.
        if (accept && last_i) stateD = Head;
      end
      default: stateD = Head;
    endcase
  end

  floo_route_fifo #(
    .PayloadWidth(DataWidth + 1),
    .Depth       (FifoDepth)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (push),
    .pushPayload({data_i, last_i}),
    .pushDir    (pushDir),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .headPayload(headPayload),
    .headDir    (headDir)
  );

  always_comb begin
    valid_o = '0;
    for (int unsigned d = 0; d < NumDirections; d++) begin
      valid_o[d] = !empty && (headDir == 3'(d));
    end
  end

  // Only the ready bit of the head's own direction can pop, since valid_o is one-hot.
  assign pop    = |(valid_o & ready_i);
  assign data_o = headPayload[DataWidth:1];
  assign last_o = headPayload[0];
  assign dir_o  = headDir;

endmodule

// File: tb/tb_floo_xy_route_stage.sv
// tb/tb_floo_xy_route_stage.sv - self-checking bench for floo_xy_route_stage
module tb_floo_xy_route_stage;

  localparam int Depth = 2;
  localparam int MyX   = 1;
  localparam int MyY   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  my_x_i = 3'(MyX);
  logic [2:0]  my_y_i = 3'(MyY);
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [63:0] data_i = '0;
  logic [2:0]  dst_x_i = '0;
  logic [2:0]  dst_y_i = '0;
  logic        last_i = 1'b0;
  logic [4:0]  valid_o;
  logic [4:0]  ready_i = 5'b11111;
  logic [63:0] data_o;
  logic        last_o;
  logic [2:0]  dir_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  floo_xy_route_stage dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .my_x_i (my_x_i),
    .my_y_i (my_y_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .dst_x_i(dst_x_i),
    .dst_y_i(dst_y_i),
    .last_i (last_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .last_o (last_o),
    .dir_o  (dir_o),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: direction names 0=N 1=E 2=S 3=W 4=Eject.
  function automatic int modelDir(input int dx, input int dy);
    if (dx > MyX) return 1;
    if (dx < MyX) return 3;
    if (dy > MyY) return 0;
    if (dy < MyY) return 2;
    return 4;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          dir;
  } flit_t;

  flit_t q[$];
  bit    inPkt = 0;
  bit    dropPkt = 0;
  int    lockDir = 0;
  bit    errExp = 0;

  // Packet-level model: a queue of flits that must leave in order, each
  // visible one cycle after it was accepted.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_valid_low", 64'(valid_o), 64'd0);
      q.delete();
      inPkt   = 0;
      dropPkt = 0;
      errExp  = 0;
    end else begin
      bit    pop, acc, drop;
      int    dir;
      flit_t f;
      check("model_valid", 64'(valid_o), (q.size() > 0) ? 64'(5'b1 << q[0].dir) : 64'd0);
      check("model_ready", 64'(ready_o), 64'(q.size() < Depth));
      check("model_err", 64'(err_o), 64'(errExp));
      if (q.size() > 0) begin
        check("model_data", data_o, q[0].data);
        check("model_last", 64'(last_o), 64'(q[0].last));
        check("model_dir", 64'(dir_o), 64'(q[0].dir));
      end
      pop = (q.size() > 0) && ready_i[q[0].dir];
      acc = valid_i && (q.size() < Depth);
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (!inPkt) begin
          dir  = modelDir(int'(dst_x_i), int'(dst_y_i));
          drop = 0;
`ifdef FLOO_XY_ROUTE_ERR_EN
          drop = (int'(dst_x_i) >= 4) || (int'(dst_y_i) >= 4);
          if (drop) errExp = 1;
`endif
          lockDir = dir;
          dropPkt = drop;
        end else begin
          dir  = lockDir;
          drop = dropPkt;
        end
        inPkt = !last_i;
        if (!drop) begin
          f.data = data_i;
          f.last = last_i;
          f.dir  = dir;
          q.push_back(f);
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input int dx, input int dy, input logic l);
    int n = 0;
    valid_i = 1'b1;
    data_i  = d;
    dst_x_i = 3'(dx);
    dst_y_i = 3'(dy);
    last_i  = l;
    while (!ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("send_accept_ready", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_valid_o", 64'(valid_o), 64'd0);
    check("rst_ready_o", 64'(ready_o), 64'd1);
    check("rst_data_o", data_o, 64'd0);
    check("rst_last_o", 64'(last_o), 64'd0);
    check("rst_dir_o", 64'(dir_o), 64'd0);
    check("rst_err_o", 64'(err_o), 64'd0);

    // Single-flit routes from (1,1); each flit shows up one cycle after accept.
    send(64'hA1, 3, 0, 1'b1);
    check("route_east_valid", 64'(valid_o), 64'h02);
    check("route_east_dir", 64'(dir_o), 64'd1);
    check("route_east_data", data_o, 64'hA1);
    send(64'hA2, 0, 2, 1'b1);
    check("route_west_dir", 64'(dir_o), 64'd3);
    send(64'hA3, 1, 3, 1'b1);
    check("route_north_dir", 64'(dir_o), 64'd0);
    check("route_north_valid", 64'(valid_o), 64'h01);
    send(64'hA4, 1, 0, 1'b1);
    check("route_south_dir", 64'(dir_o), 64'd2);
    send(64'hA5, 1, 1, 1'b1);
    check("route_eject_dir", 64'(dir_o), 64'd4);
    check("route_eject_valid", 64'(valid_o), 64'h10);
    @(posedge clk); #1;

    // Locked direction across a 4-flit packet.
    send(64'hB1, 3, 1, 1'b0);
    send(64'hB2, 0, 0, 1'b0);
    check("lock_body_dir", 64'(dir_o), 64'd1);
    check("lock_body_last", 64'(last_o), 64'd0);
    send(64'hB3, 0, 0, 1'b0);
    send(64'hB4, 0, 0, 1'b1);
    check("lock_tail_dir", 64'(dir_o), 64'd1);
    check("lock_tail_last", 64'(last_o), 64'd1);
    send(64'hB5, 0, 1, 1'b1);
    check("lock_next_head_west", 64'(dir_o), 64'd3);
    @(posedge clk); #1;

    // Backpressure on East only.
    ready_i = 5'b11101;
    send(64'hC0, 3, 1, 1'b1);
    send(64'hC1, 3, 1, 1'b1);
    check("bp_ready_low", 64'(ready_o), 64'd0);
    check("bp_head_data", data_o, 64'hC0);
    valid_i = 1'b1;
    data_i  = 64'hC2;
    dst_x_i = 3'd3;
    dst_y_i = 3'd1;
    last_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ready", 64'(ready_o), 64'd0);
      check("bp_hold_data", data_o, 64'hC0);
    end
    ready_i = 5'b11111;
    @(posedge clk); #1;
    check("bp_drain_1", data_o, 64'hC1);
    check("bp_ready_back", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("bp_drain_2", data_o, 64'hC2);
    @(posedge clk); #1;
    check("bp_empty", 64'(valid_o), 64'd0);

    // Full throughput: one flit in and out every cycle.
    for (int i = 0; i < 6; i++) begin
      check("tput_ready", 64'(ready_o), 64'd1);
      send(64'hD0 + 64'(i), 0, 1, 1'b1);
      check("tput_valid", 64'(valid_o), 64'h08);
      check("tput_data", data_o, 64'hD0 + 64'(i));
    end
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a 3-flit packet.
    send(64'hE0, 1, 2, 1'b0);
    send(64'hE1, 0, 0, 1'b0);
    check("midrst_pre_valid", 64'(valid_o), 64'h01);
    rst = 1'b1;
    #1;
    check("midrst_async_valid", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(64'hE2, 2, 1, 1'b1);
    check("midrst_head_east", 64'(dir_o), 64'd1);
    check("midrst_head_data", data_o, 64'hE2);
    @(posedge clk); #1;

`ifdef FLOO_XY_ROUTE_ERR_EN
    send(64'hF0, 5, 0, 1'b0);
    check("err_set", 64'(err_o), 64'd1);
    check("err_no_valid_0", 64'(valid_o), 64'd0);
    send(64'hF1, 0, 0, 1'b0);
    check("err_no_valid_1", 64'(valid_o), 64'd0);
    send(64'hF2, 0, 0, 1'b1);
    check("err_no_valid_2", 64'(valid_o), 64'd0);
    send(64'hF3, 0, 1, 1'b1);
    check("err_next_west", 64'(dir_o), 64'd3);
    check("err_sticky", 64'(err_o), 64'd1);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
